l2_ewb: RTL
===========

// Module: l2_ewb
// PURPOSE
// - Eviction write buffer between l2_cache's pmem port and physical memory.
// - Upstream, it is the responder to the L2 for line reads and dirty-line evictions.
// - Evictions are buffered and acked quickly, then drained to memory in FIFO order.
// - Line fills are issued with priority over draining, so a miss never waits behind a writeback.
// PARAMETERS
// - DEPTH  2  buffered 256-bit lines; power of 2, >=1
// PORTS
// - clk            in   1    clock; all state updates on rising edge
// - rst_n          in   1    asynchronous active-low reset
// - l2_read        in   1    L2 line-read request; held until l2_resp
// - l2_write       in   1    L2 eviction request; held until l2_resp
// - l2_address     in   16   read address (lc3b_word)
// - l2_waddress    in   16   eviction address (lc3b_word)
// - l2_wdata       in   256  eviction line (lc3b_pmem_data)
// - l2_resp        out  1    one-cycle completion pulse to L2
// - l2_rdata       out  256  read line; valid while l2_resp=1
// - ewb_ready      out  1    1 = a free entry exists (count<DEPTH)
// - pmem_read      out  1    memory read; held until pmem_resp
// - pmem_write     out  1    memory write; held until pmem_resp
// - pmem_address   out  16   line-aligned address {addr[15:5],5'b0}
// - pmem_wdata     out  256  line being drained
// - pmem_resp      in   1    memory completion, one cycle
// - pmem_rdata     in   256  memory read line; valid with pmem_resp
// BEHAVIOUR
// - Reset values:
//   - l2_resp, pmem_read, pmem_write = 0; l2_rdata, pmem_address, pmem_wdata = 0.
//   - count = 0, head/tail pointers = 0, FSM = IDLE, ewb_ready = 1.
// - Line match: addr[15:5] equality. Entries hold line address and data.
// - Request acceptance:
//   - No request is accepted in the cycle l2_resp=1; the L2 is still holding its old request then.
//   - If l2_write and l2_read are both high, the write is accepted first and the read is considered from the next cycle.
// - Write accept: l2_write && count<DEPTH.
//   - Enqueue at tail and pulse l2_resp in the next cycle.
//   - Full: no accept, no l2_resp; the L2 stalls holding the request.
//   - Duplicate lines are enqueued, not merged; FIFO drain order makes the youngest copy win.
// - Downstream FSM has three states: IDLE, READ and DRAIN.
//   - IDLE -> READ: when l2_read is pending, is not yet served, and no entry matches.
//     - Drive pmem_read and pmem_address from l2_address.
//   - IDLE -> DRAIN: otherwise, when count>0.
//     - Drive pmem_write, pmem_address and pmem_wdata from the head entry.
//   - READ: on pmem_resp, latch pmem_rdata into l2_rdata, pulse l2_resp next cycle, go to IDLE.
//   - DRAIN: on pmem_resp, dequeue head and go to IDLE.
//   - No preemption: an in-flight memory transaction always completes.
//   - pmem_read and pmem_write are never both 1.
// - Enqueue and dequeue in the same cycle leave count unchanged; ewb_ready does not glitch.
// - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).
// - Read to a buffered line:
//   - Without forwarding, the FSM drains, oldest first, until no entry matches, then issues READ.
//   - Memory is therefore never read stale.
// - Reset mid-transaction: buffered entries are discarded and outputs drop immediately.
//   - The memory model must tolerate an abandoned request.
// CONFIGURATION
// - EWB_FWD_EN defined:
//   - A read matching a buffered entry is served from the youngest matching entry.
//   - l2_rdata is loaded and l2_resp pulses one cycle after the read is observed.
//   - No memory access is made; the entry stays queued.
// - EWB_FWD_EN undefined: drain-before-read as in BEHAVIOUR. Matching logic is kept for hazard detection only.
// TESTING
// - Write 0x1240, data D0, empty buffer -> l2_resp at +1 cycle; later pmem_write addr 0x1240, data D0.
// - Fill DEPTH=2 with 0x0020, 0x0040; write 0x0060 -> ewb_ready=0, no l2_resp until the first drain's pmem_resp.
// - Entry 0x0020 queued; read 0x3000 -> pmem_read 0x3000 issued before any drain; l2_rdata equals pmem_rdata at l2_resp.
// - Entry 0x0020 = D1; read 0x002A:
//   - without EWB_FWD_EN -> pmem_write 0x0020 first, then pmem_read 0x0020;
//   - with EWB_FWD_EN -> l2_rdata = D1 at +1 cycle, no pmem_read.
// - Write 0x0080 accepted in the same cycle a drain's pmem_resp arrives at count=2 -> count stays 2, no lost entry.
// - rst_n low during DRAIN -> pmem_write=0 immediately, ewb_ready=1, no drain after release.

Source files
------------

// File: rtl/l2_ewb.sv
// Eviction write buffer between the L2 pmem port and physical memory: evictions are acked
// immediately and drained in FIFO order, line fills take priority. Define EWB_FWD_EN to serve reads from buffered lines.
module l2_ewb #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         l2_read,
    input  logic         l2_write,
    input  logic [15:0]  l2_address,
    input  logic [15:0]  l2_waddress,
    input  logic [255:0] l2_wdata,
    output logic         l2_resp,
    output logic [255:0] l2_rdata,
    output logic         ewb_ready,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state_reg;
    logic [10:0]        line_mem [DEPTH];
    logic [255:0]       data_mem [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DEPTH-1:0]   valid_vec;
    logic [DEPTH-1:0]   hit_vec;
    logic               hit_any;
    logic               deq;
    logic               wr_accept;
    logic               read_req;
    logic               fwd_serve;
    logic               unused_bits;

    assign unused_bits = ^{l2_address[4:0], l2_waddress[4:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An entry is live when its distance from head is below the occupancy count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off           = PTR_W'(gi) - head_reg;
        assign valid_vec[gi] = CNT_W'(off) < count_reg;
        assign hit_vec[gi]   = valid_vec[gi] && (line_mem[gi] == l2_address[15:5]);
    end

    assign hit_any   = |hit_vec;
    assign deq       = (state_reg == DRAIN) && pmem_resp;
    // A slot freed by the drain completing this cycle can take the new eviction.
    assign wr_accept = l2_write && !l2_resp && ((count_reg < CNT_W'(DEPTH)) || deq);
    // The L2 still holds its old request while l2_resp is high; a write goes ahead of a read.
    assign read_req  = l2_read && !l2_write && !l2_resp;
    assign ewb_ready = count_reg < CNT_W'(DEPTH);

`ifdef EWB_FWD_EN
    logic [255:0]     fwd_data;
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching copy is the one forwarded.
    always_comb begin
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if (hit_vec[fwd_idx]) begin
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

    assign fwd_serve = read_req && hit_any && (state_reg != READ);
`else
    assign fwd_serve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            line_mem[tail_reg] <= l2_waddress[15:5];
            data_mem[tail_reg] <= l2_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_accept) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (deq) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (wr_accept && !deq) begin
                count_reg <= count_reg + 1'b1;
            end else if (!wr_accept && deq) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            l2_resp      <= 1'b0;
            l2_rdata     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            l2_resp <= wr_accept || fwd_serve;
`ifdef EWB_FWD_EN
            if (fwd_serve) begin
                l2_rdata <= fwd_data;
            end
`endif
            case (state_reg)
                IDLE: begin
                    if (read_req && !hit_any) begin
                        pmem_read    <= 1'b1;
                        pmem_address <= {l2_address[15:5], 5'b0};
                        state_reg    <= READ;
                    end else if (count_reg != '0) begin
                        // Also the hazard path: a read to a buffered line drains until no match.
                        pmem_write   <= 1'b1;
                        pmem_address <= {line_mem[head_reg], 5'b0};
                        pmem_wdata   <= data_mem[head_reg];
                        state_reg    <= DRAIN;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        l2_rdata  <= pmem_rdata;
                        l2_resp   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
